// File: rtl/win_addr_gen_if.sv
// Valid/ready transfer channel: a word moves in any cycle where valid & ready.
interface dti #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/win_addr_gen.sv
// Window address generator: takes one (x0, y0, w, h) command and scans it
// row-major, emitting addr = (y0+j)*IMG_WIDTH + (x0+i) with eot on the last word.
module win_addr_gen #(
  parameter int W_ADDR    = 16,
  parameter int W_COORD   = 8,
  parameter int IMG_WIDTH = 320
) (
  input  logic  clk,
  input  logic  rst,
  dti.consumer  cfg_if,
  dti.producer  addr_if
);

  localparam logic [W_ADDR-1:0] IMG_STRIDE = W_ADDR'(IMG_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [W_COORD-1:0]  x0_q, x0_d;
  logic [W_COORD-1:0]  y0_q, y0_d;
  logic [W_COORD-1:0]  w_q, w_d;
  logic [W_COORD-1:0]  h_q, h_d;
  logic [W_COORD-1:0]  i_q, i_d;
  logic [W_COORD-1:0]  j_q, j_d;
  logic [W_ADDR-1:0]   row_base_q, row_base_d;

  logic                cfg_ready;
  logic                addr_valid;
  logic                cfg_fire;
  logic                addr_fire;
  logic                last_col;
  logic                last_row;
  logic                eot;
  logic [W_ADDR-1:0]   addr;

  // Start of the first row; the only multiply, done once per window.
  function automatic logic [W_ADDR-1:0] window_base(input logic [W_COORD-1:0] y0,
                                                    input logic [W_COORD-1:0] x0);
    logic [W_ADDR-1:0] y_ext;
    logic [W_ADDR-1:0] prod;
    y_ext = W_ADDR'(y0);
    prod  = y_ext * IMG_STRIDE;
    return prod + W_ADDR'(x0);
  endfunction

  assign last_col   = (i_q == w_q - W_COORD'(1));
  assign last_row   = (j_q == h_q - W_COORD'(1));
  assign eot        = last_col && last_row;
  assign addr       = row_base_q + W_ADDR'(i_q);

  // Reset masks both handshakes so nothing moves while rst is high.
  assign cfg_fire   = cfg_ready && cfg_if.valid && !rst;
  assign addr_fire  = addr_valid && addr_if.ready && !rst;

  assign cfg_if.ready  = cfg_ready && !rst;
  assign addr_if.valid = addr_valid && !rst;
  assign addr_if.data  = {eot && addr_valid, addr};

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    i_d        = i_q;
    j_d        = j_q;
    row_base_d = row_base_q;
    cfg_ready  = 1'b0;
    addr_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_fire) begin
          x0_d    = cfg_if.data[W_COORD-1:0];
          y0_d    = cfg_if.data[2*W_COORD-1:W_COORD];
          w_d     = cfg_if.data[3*W_COORD-1:2*W_COORD];
          h_d     = cfg_if.data[4*W_COORD-1:3*W_COORD];
          state_d = LOAD;
        end
      end

      LOAD: begin
        if ((w_q == '0) || (h_q == '0)) begin
          state_d = IDLE;
        end else begin
          row_base_d = window_base(y0_q, x0_q);
          i_d        = '0;
          j_d        = '0;
          state_d    = RUN;
        end
      end

      RUN: begin
        addr_valid = 1'b1;
        if (addr_fire) begin
          if (!last_col) begin
            i_d = i_q + W_COORD'(1);
          end else if (!last_row) begin
            i_d        = '0;
            j_d        = j_q + W_COORD'(1);
            row_base_d = row_base_q + IMG_STRIDE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      row_base_q <= row_base_d;
    end
  end

  // Command fields are only consumed after LOAD, so they need no reset.
  always_ff @(posedge clk) begin
    x0_q <= x0_d;
    y0_q <= y0_d;
    w_q  <= w_d;
    h_q  <= h_d;
  end

endmodule
